// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM states,
// datapath mux-select codes and the packed control word.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_RTYPEEX = 4'd7,
    S_RTYPEWB = 4'd8,
    S_BEQEX   = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JEX     = 4'd12
  } state_t;

  localparam logic [1:0] ASB_B       = 2'b00;
  localparam logic [1:0] ASB_FOUR    = 2'b01;
  localparam logic [1:0] ASB_IMM     = 2'b10;
  localparam logic [1:0] ASB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwe;
    logic       branch;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       instr_done;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] o);
    return (o == OP_LW) || (o == OP_SW) || (o == OP_RTYPE) ||
           (o == OP_BEQ) || (o == OP_ADDI) || (o == OP_J);
  endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Pure combinational state -> control-word decode (Moore outputs), zero latency;
// no flow control, unused encodings and IDLE decode to an all-zero word.
module ctrl_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.irwrite = 1'b1;
        ctrl.alusrcb = ASB_FOUR;
        ctrl.pcwe    = 1'b1;
      end
      S_DECODE: begin
        ctrl.alusrcb = ASB_IMM_SH2;
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ASB_IMM;
      end
      S_MEMRD: begin
        ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.memtoreg   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord       = 1'b1;
        ctrl.memwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ASB_B;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl.regdst     = 1'b1;
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BEQEX: begin
        // branch, not pcwe: the PC-enable logic qualifies it with ALU zero
        ctrl.alusrca    = 1'b1;
        ctrl.aluop      = ALUOP_SUB;
        ctrl.branch     = 1'b1;
        ctrl.pcsrc      = PCSRC_ALUOUT;
        ctrl.instr_done = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ASB_IMM;
      end
      S_ADDIWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JEX: begin
        ctrl.pcsrc      = PCSRC_JUMP;
        ctrl.pcwe       = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control FSM: 2-5 cycles per instruction from FETCH to done state.
// No handshake; op must be held by the IR through DECODE and MEMADR.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [OP_W-1:0] op,
  output logic            pcwe,
  output logic            branch,
  output logic            iord,
  output logic            memwrite,
  output logic            irwrite,
  output logic            regdst,
  output logic            memtoreg,
  output logic            regwrite,
  output logic            alusrca,
  output logic [1:0]      alusrcb,
  output logic [1:0]      aluop,
  output logic [1:0]      pcsrc,
  output logic            instr_done,
  output logic            illegal_op,
  output logic [ST_W-1:0] state
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = S_IDLE;
    illegal_op = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_FETCH;
        endcase
        illegal_op = !op_supported(op);
      end
      S_MEMADR: begin
        // op is sampled again here; anything but LW/SW means the IR moved, so abandon
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
        else                  state_d = S_FETCH;
      end
      S_MEMRD:   state_d = S_MEMWB;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_RTYPEWB, S_BEQEX, S_ADDIWB, S_JEX:
                 state_d = S_FETCH;
      default:   state_d = S_IDLE;
    endcase
  end

  ctrl_output_decode u_decode (
    .state (state_q),
    .ctrl  (ctrl)
  );

  assign pcwe       = ctrl.pcwe;
  assign branch     = ctrl.branch;
  assign iord       = ctrl.iord;
  assign memwrite   = ctrl.memwrite;
  assign irwrite    = ctrl.irwrite;
  assign regdst     = ctrl.regdst;
  assign memtoreg   = ctrl.memtoreg;
  assign regwrite   = ctrl.regwrite;
  assign alusrca    = ctrl.alusrca;
  assign alusrcb    = ctrl.alusrcb;
  assign aluop      = ctrl.aluop;
  assign pcsrc      = ctrl.pcsrc;
  assign instr_done = ctrl.instr_done;
  assign state      = ST_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: stimulus pushes per-cycle expected control words, a negedge monitor pops and compares.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic       pcwe, branch, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic       instr_done, illegal_op;
  logic [3:0] state;

  multicycle_control_fsm dut (
    .clk(clk), .reset_n(reset_n), .op(op),
    .pcwe(pcwe), .branch(branch), .iord(iord), .memwrite(memwrite),
    .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc),
    .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  // Vector layout: pcwe branch iord memwrite irwrite regdst memtoreg regwrite alusrca
  //                alusrcb[2] aluop[2] pcsrc[2] instr_done illegal_op
  localparam logic [16:0] PCWE = 17'h10000, BR = 17'h08000, IORD = 17'h04000, MW = 17'h02000;
  localparam logic [16:0] IRW = 17'h01000, RD = 17'h00800, MTR = 17'h00400, RW = 17'h00200;
  localparam logic [16:0] ASA = 17'h00100, DONE = 17'h00002, ILL = 17'h00001;

  function automatic logic [16:0] asb(input int v);  return 17'(v) << 6; endfunction
  function automatic logic [16:0] aop(input int v);  return 17'(v) << 4; endfunction
  function automatic logic [16:0] psrc(input int v); return 17'(v) << 2; endfunction

  typedef struct {
    logic [16:0] vec;
    bit          idle;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   done_seen = 0;

  function automatic logic [16:0] dut_vec();
    return {pcwe, branch, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
            alusrcb, aluop, pcsrc, instr_done, illegal_op};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, req);
    end
  endtask

  // Reference model: the step sequence each instruction class walks through.
  function automatic bit is_legal(input logic [5:0] o);
    return o == LW || o == SW || o == RT || o == BEQ || o == ADDI || o == JMP;
  endfunction

  function automatic int instr_len(input logic [5:0] o);
    if (o == LW) return 5;
    if (o == SW || o == RT || o == ADDI) return 4;
    if (o == BEQ || o == JMP) return 3;
    return 2;
  endfunction

  function automatic logic [16:0] exp_step(input logic [5:0] o, input int i);
    if (i == 0) return PCWE | IRW | asb(1);
    if (i == 1) return asb(3) | (is_legal(o) ? 17'h0 : ILL);
    case (o)
      LW:   return (i == 2) ? (ASA | asb(2)) : (i == 3) ? IORD : (RW | MTR | DONE);
      SW:   return (i == 2) ? (ASA | asb(2)) : (IORD | MW | DONE);
      RT:   return (i == 2) ? (ASA | aop(2)) : (RD | RW | DONE);
      ADDI: return (i == 2) ? (ASA | asb(2)) : (RW | DONE);
      BEQ:  return ASA | aop(1) | BR | psrc(1) | DONE;
      JMP:  return psrc(2) | PCWE | DONE;
      default: return 17'h0;
    endcase
  endfunction

  task automatic push(input logic [16:0] v, input bit idle);
    exp_t e;
    e.vec = v;
    e.idle = idle;
    q.push_back(e);
  endtask

  task automatic run_instr(input logic [5:0] o);
    for (int i = 0; i < instr_len(o); i++) begin
      @(posedge clk);
      #1;
      // op only matters in DECODE/MEMADR; later cycles get junk
      op = (i < 3) ? o : 6'($urandom);
      push(exp_step(o, i), 1'b0);
    end
  endtask

  task automatic idle_cycle(input bit release_rst);
    @(posedge clk);
    #1;
    if (release_rst) reset_n = 1'b1;
    push(17'h0, 1'b1);
  endtask

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (instr_done) done_seen++;
    chk("pcwe_branch_excl", 32'(pcwe & branch), 32'd0);
    chk("mw_rw_excl", 32'(memwrite & regwrite), 32'd0);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ctrl_word", 32'(dut_vec()), 32'(e.vec));
      if (e.idle) chk("idle_state", 32'(state), 32'd0);
    end
  end

  initial begin
    int d0;
    logic [5:0] o;

    idle_cycle(1'b0);
    idle_cycle(1'b0);
    idle_cycle(1'b1);

    run_instr(LW);
    run_instr(BEQ);

    sync();
    d0 = done_seen;
    run_instr(RT);
    run_instr(JMP);
    sync();
    chk("done_pair", 32'(done_seen - d0), 32'd2);

    run_instr(6'b111111);

    // SW aborted by reset during MEMADR
    run_instr_partial_sw();

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 7))
        0: o = LW;
        1: o = SW;
        2: o = RT;
        3: o = BEQ;
        4: o = ADDI;
        5: o = JMP;
        default: o = 6'($urandom);
      endcase
      run_instr(o);
    end

    sync();
    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic run_instr_partial_sw();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      op = SW;
      push(exp_step(SW, i), 1'b0);
    end
    @(posedge clk);
    #1;
    op = SW;
    push(17'h0, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_outputs", 32'(dut_vec()), 32'd0);
    chk("async_rst_memwrite", 32'(memwrite), 32'd0);
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    idle_cycle(1'b1);
    run_instr(SW);
  endtask

endmodule
